// File: rtl/clock_pkg.sv
// Shared clock constants, FSM encodings and calendar helpers for the ps1_clock datapath.
package clock_pkg;

  localparam int unsigned TW_DEF       = 28;
  localparam int unsigned DIV_W        = 17;
  localparam int unsigned DAYS_W       = 12;
  localparam int unsigned SEC_PER_DAY  = 86400;
  localparam int unsigned SEC_PER_HOUR = 3600;
  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned DAYS_PER_WK  = 7;
  localparam int unsigned EPOCH_YEAR   = 2020;
  localparam int unsigned EPOCH_WDAY   = 3;
  // Days from 1970-01-01 to 2020-01-01, used by the forward converter.
  localparam int unsigned EPOCH_DAY    = 18262;

  // Decoder FSM encodings.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DIV_DAY = 3'd1;
  localparam logic [2:0] ST_DIV_HR  = 3'd2;
  localparam logic [2:0] ST_DIV_MIN = 3'd3;
  localparam logic [2:0] ST_DIV_WD  = 3'd4;
  localparam logic [2:0] ST_YEAR    = 3'd5;
  localparam logic [2:0] ST_MONTH   = 3'd6;
  localparam logic [2:0] ST_FIN     = 3'd7;

  // Length of month m (1..12); February depends on leap.
  function automatic logic [4:0] mlen(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                   mlen = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
      default:                mlen = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/unix_calendar_decoder_if.sv
// Request/result bundle between the seconds counter and the calendar decoder.
interface unix_calendar_decoder_if #(parameter int unsigned TW = 28);
  logic          start;
  logic [TW-1:0] t;
  logic          busy;
  logic          done;
  logic [3:0]    year_off;
  logic [3:0]    month;
  logic [4:0]    day;
  logic [4:0]    hour;
  logic [5:0]    minute;
  logic [5:0]    second;
  logic [2:0]    wday;

  modport master (output start, t,
                  input  busy, done, year_off, month, day, hour, minute, second, wday);
  modport slave  (input  start, t,
                  output busy, done, year_off, month, day, hour, minute, second, wday);
endinterface

// File: rtl/unix_calendar_decoder_divider.sv
// Restoring divider: one load cycle, then one quotient bit per cycle.
module seq_divider #(
  parameter int unsigned TW = 28,
  parameter int unsigned DW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [TW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [TW-1:0] quot_o,
  output logic [DW-1:0] rem_o
);
  localparam int unsigned CW = $clog2(TW + 1);

  logic [TW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [DW:0]   shifted_c;

  // Load on start, otherwise shift in one dividend bit and try a subtraction.
  always_comb begin
    quot_d    = quot_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shifted_c = {rem_q, quot_q[TW-1]};
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dsr_d  = divisor_i;
      cnt_d  = CW'(TW);
    end else if (cnt_q != '0) begin
      if (shifted_c >= {1'b0, dsr_q}) begin
        rem_d  = DW'(shifted_c - {1'b0, dsr_q});
        quot_d = {quot_q[TW-2:0], 1'b1};
      end else begin
        rem_d  = DW'(shifted_c);
        quot_d = {quot_q[TW-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/unix_calendar_decoder.sv
// Decodes seconds since 2020-01-01 into calendar and time-of-day fields.
module unix_calendar_decoder
  import clock_pkg::*;
#(
  parameter int unsigned TW         = clock_pkg::TW_DEF,
  parameter int unsigned EPOCH_WDAY = clock_pkg::EPOCH_WDAY
) (
  input logic                     clk,
  input logic                     rst,
  unix_calendar_decoder_if.slave  bus
);
  logic [2:0]        state_q, state_d;
  logic              div_start_c, div_done;
  logic [TW-1:0]     div_dividend_c, div_quot;
  logic [DIV_W-1:0]  div_divisor_c, div_rem;
  logic [DAYS_W-1:0] days_q, days_d, ylen_c, mlen_c;
  logic [3:0]        yr_q, yr_d, mon_q, mon_d;
  logic [4:0]        hr_q, hr_d;
  logic [5:0]        min_q, min_d, sec_q, sec_d;
  logic [2:0]        wd_q, wd_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [3:0]        year_off_q, year_off_d, month_q, month_d;
  logic [4:0]        day_q, day_d, hour_q, hour_d;
  logic [5:0]        minute_q, minute_d, second_q, second_d;
  logic [2:0]        wday_q, wday_d;
  logic              unused_quot_c;

  seq_divider #(.TW(TW), .DW(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_c),
    .dividend_i (div_dividend_c),
    .divisor_i  (div_divisor_c),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  assign unused_quot_c = ^div_quot[TW-1:DAYS_W];
  assign ylen_c = (yr_q[1:0] == 2'd0) ? DAYS_W'(366) : DAYS_W'(365);
  assign mlen_c = DAYS_W'(mlen(mon_q, yr_q[1:0] == 2'd0));

  // Next state, divider sequencing and result publication.
  always_comb begin
    state_d        = state_q;
    div_start_c    = 1'b0;
    div_dividend_c = '0;
    div_divisor_c  = '0;
    days_d         = days_q;
    yr_d           = yr_q;
    mon_d          = mon_q;
    hr_d           = hr_q;
    min_d          = min_q;
    sec_d          = sec_q;
    wd_d           = wd_q;
    done_d         = 1'b0;
    year_off_d     = year_off_q;
    month_d        = month_q;
    day_d          = day_q;
    hour_d         = hour_q;
    minute_d       = minute_q;
    second_d       = second_q;
    wday_d         = wday_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        div_start_c    = 1'b1;
        div_dividend_c = bus.t;
        div_divisor_c  = DIV_W'(SEC_PER_DAY);
        yr_d           = 4'd0;
        mon_d          = 4'd1;
        state_d        = ST_DIV_DAY;
      end
      ST_DIV_DAY: if (div_done) begin
        days_d         = DAYS_W'(div_quot);
        div_start_c    = 1'b1;
        div_dividend_c = TW'(div_rem);
        div_divisor_c  = DIV_W'(SEC_PER_HOUR);
        state_d        = ST_DIV_HR;
      end
      ST_DIV_HR: if (div_done) begin
        hr_d           = 5'(div_quot);
        div_start_c    = 1'b1;
        div_dividend_c = TW'(div_rem);
        div_divisor_c  = DIV_W'(SEC_PER_MIN);
        state_d        = ST_DIV_MIN;
      end
      ST_DIV_MIN: if (div_done) begin
        min_d          = 6'(div_quot);
        sec_d          = 6'(div_rem);
        div_start_c    = 1'b1;
        div_dividend_c = TW'(days_q) + TW'(EPOCH_WDAY);
        div_divisor_c  = DIV_W'(DAYS_PER_WK);
        state_d        = ST_DIV_WD;
      end
      ST_DIV_WD: if (div_done) begin
        wd_d    = 3'(div_rem);
        state_d = ST_YEAR;
      end
      ST_YEAR: begin
        if (days_q >= ylen_c) begin
          days_d = days_q - ylen_c;
          yr_d   = yr_q + 4'd1;
        end else begin
          state_d = ST_MONTH;
        end
      end
      ST_MONTH: begin
        if (days_q >= mlen_c) begin
          days_d = days_q - mlen_c;
          mon_d  = mon_q + 4'd1;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        year_off_d = yr_q;
        month_d    = mon_q;
        day_d      = 5'(days_q) + 5'd1;
        hour_d     = hr_q;
        minute_d   = min_q;
        second_d   = sec_q;
        wday_d     = wd_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, working and output registers; reset aborts any decode in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      days_q     <= '0;
      yr_q       <= '0;
      mon_q      <= 4'd1;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      year_off_q <= '0;
      month_q    <= 4'd1;
      day_q      <= 5'd1;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      wday_q     <= 3'(EPOCH_WDAY);
    end else begin
      state_q    <= state_d;
      days_q     <= days_d;
      yr_q       <= yr_d;
      mon_q      <= mon_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      year_off_q <= year_off_d;
      month_q    <= month_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      wday_q     <= wday_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.year_off = year_off_q;
  assign bus.month    = month_q;
  assign bus.day      = day_q;
  assign bus.hour     = hour_q;
  assign bus.minute   = minute_q;
  assign bus.second   = second_q;
  assign bus.wday     = wday_q;
endmodule

// File: tb/tb_unix_calendar_decoder.sv
// Directed-vector bench for unix_calendar_decoder.
module tb_unix_calendar_decoder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unix_calendar_decoder_if bus ();

  unix_calendar_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_fields(input string p, input int y, input int m, input int d,
                            input int h, input int mi, input int s, input int w);
    chk({p, ".year_off"}, 32'(bus.year_off), 32'(y));
    chk({p, ".month"},    32'(bus.month),    32'(m));
    chk({p, ".day"},      32'(bus.day),      32'(d));
    chk({p, ".hour"},     32'(bus.hour),     32'(h));
    chk({p, ".minute"},   32'(bus.minute),   32'(mi));
    chk({p, ".second"},   32'(bus.second),   32'(s));
    chk({p, ".wday"},     32'(bus.wday),     32'(w));
  endtask

  // Issue one start pulse; returns at the first negedge after the accepting edge.
  task automatic kick(input logic [27:0] tt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.t     = tt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input string p, input logic [27:0] tt, input int y, input int m,
                         input int d, input int h, input int mi, input int s, input int w);
    int  lat;
    bit  seen;
    kick(tt);
    chk({p, ".busy_after_start"}, 32'(bus.busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      lat = i + 1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({p, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({p, ".latency_le_139"}, 32'(lat <= 139), 32'd1);
      chk({p, ".busy_in_done"}, 32'(bus.busy), 32'd0);
      chk_fields(p, y, m, d, h, mi, s, w);
      @(negedge clk);
      chk({p, ".done_one_cycle"}, 32'(bus.done), 32'd0);
      chk_fields({p, ".hold"}, y, m, d, h, mi, s, w);
    end
  endtask

  initial begin
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.t     = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk_fields("rst", 0, 1, 1, 0, 0, 0, 3);
    rst = 1'b0;

    run_vec("t0",        28'd0,         0, 1, 1,  0,  0,  0, 3);
    run_vec("t86399",    28'd86399,     0, 1, 1, 23, 59, 59, 3);
    run_vec("leap_feb",  28'd5097600,   0, 2, 29, 0,  0,  0, 6);
    run_vec("new_year",  28'd31622400,  1, 1, 1,  0,  0,  0, 5);
    run_vec("dec31",     28'd31622399,  0, 12, 31, 23, 59, 59, 4);
    run_vec("tmax",      28'd268435455, 8, 7, 3, 21, 24, 15, 1);

    // Second start while busy must be dropped, not queued.
    ndone = 0;
    kick(28'd86399);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.t     = 28'd31622400;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("ignore.done_count", 32'(ndone), 32'd1);
    chk_fields("ignore", 0, 1, 1, 23, 59, 59, 3);

    // Reset mid-decode aborts with no done pulse.
    kick(28'd268435455);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk_fields("abort", 0, 1, 1, 0, 0, 0, 3);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("abort.no_done", 32'(ndone), 32'd0);

    run_vec("after_rst", 28'd268435455, 8, 7, 3, 21, 24, 15, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
